imem_loader: RTL
================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning instruction memory size in 32-bit words.
REQ-002 SHALL have parameter WIDTH, default 32, meaning data word width in bits (fixed at 32 in this revision).
REQ-003 SHALL have port clk  in  1  the single system clock; all state changes on the rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-005 SHALL have port start  in  1  one-cycle pulse that begins a load.
REQ-006 SHALL have port rx_data  in  8  incoming byte.
REQ-007 SHALL have port rx_valid  in  1  rx_data is valid this cycle.
REQ-008 SHALL have port rx_ready  out  1  loader accepts a byte this cycle; a transfer occurs when rx_valid and rx_ready are both high.
REQ-009 SHALL have port WE  out  1  instruction memory write enable.
REQ-010 SHALL have port A  out  32  byte address of the write, word-aligned (A[1:0] = 0).
REQ-011 SHALL have port WD  out  WIDTH  write data.
REQ-012 SHALL have port busy  out  1  load in progress.
REQ-013 SHALL have port done  out  1  one-cycle pulse on successful completion.
REQ-014 SHALL have port err  out  1  sticky error flag, cleared by the next accepted start.

Function
REQ-015 SHALL implement the FSM states IDLE, LEN_LO, LEN_HI, DATA, WRITE, CHECK, FINISH.
REQ-016 SHALL move from IDLE to LEN_LO on start, clear err, the word counter and the byte counter, and ignore start in any other state.
REQ-017 SHALL take word count N as 16 bits, little-endian: first byte accepted in LEN_LO, second in LEN_HI.
REQ-018 SHALL go to FINISH after LEN_HI if N = 0, set err and return to IDLE if N > DEPTH, and otherwise go to DATA.
REQ-019 SHALL pack 4 accepted bytes per word, little-endian (first byte -> WD[7:0]), and enter WRITE after the 4th byte.
REQ-020 SHALL hold WE high for exactly one cycle in WRITE, with A = word_index*4 and WD = the packed word; WE is 0 in all other states.
REQ-021 SHALL increment word_index after each WRITE, return to DATA while word_index < N, and otherwise go to CHECK (macro on) or FINISH (macro off).
REQ-022 SHALL drive rx_ready high only in LEN_LO, LEN_HI, DATA and CHECK; in WRITE rx_ready is 0 (one-cycle backpressure per word).
REQ-023 SHALL hold state and partial word unchanged while rx_valid is low; gaps of any length are legal.
REQ-024 SHALL pulse done for one cycle in FINISH and then enter IDLE; busy is high in every state except IDLE.
REQ-025 SHALL leave memory contents already written untouched on error; no write is issued after err is set.

Reset
REQ-026 SHALL, on rst at any time including mid-load, immediately force state IDLE and drive rx_ready, WE, busy, done and err to 0, A to 0, WD to 0, and clear all counters.
REQ-027 SHALL accept a new start in the first cycle after rst is deasserted.

Configuration
REQ-028 SHALL use macro IMEM_LOADER_CHECKSUM_EN.
REQ-029 With IMEM_LOADER_CHECKSUM_EN defined, SHALL keep a running XOR of all payload bytes (header excluded) and accept one trailing byte in CHECK. A match goes to FINISH; a mismatch sets err and goes to IDLE without a done pulse.
REQ-030 With IMEM_LOADER_CHECKSUM_EN undefined, SHALL omit the CHECK state and the XOR register, and go from the last WRITE directly to FINISH.

Structure
REQ-031 SHALL place the state enum type, LEN_BYTES = 2 and BYTES_PER_WORD = 4 in package imem_loader_pkg.
REQ-032 SHALL place the byte-to-word little-endian packing (shift register plus 2-bit byte counter, with clear and full outputs) in sub-module imem_word_pack.

Verification
REQ-033 Bytes 02 00 | 13 00 00 00 | 93 00 10 00 -> WE pulses with A=0x0, WD=0x00000013 and A=0x4, WD=0x00100093; done one cycle after last WRITE (checksum off).
REQ-034 Header 00 00 -> no WE; done pulses; busy falls.
REQ-035 Header 01 01 (N=257 > 256) -> err=1; no WE; rx_ready=0 in IDLE; next start clears err.
REQ-036 N=1 payload 11 22 33 44, rx_valid toggled every other cycle -> single WE, WD=0x44332211, A=0; rx_ready=0 during WRITE cycle.
REQ-037 Checksum on, N=1, payload 11 22 33 44, trailer 44 -> done; trailer 45 -> err=1, no done.
REQ-038 rst asserted after 2 payload bytes -> all outputs 0 same cycle; new load of N=1 payload AA BB CC DD writes WD=0xDDCCBBAA at A=0.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// IMEM_LOADER_CHECKSUM_EN adds the CHECK state for the trailing XOR byte.
package imem_loader_pkg;

    localparam int LEN_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHECK,
`endif
        FINISH
    } state_t;

endpackage

// File: rtl/imem_word_pack.sv
// Little-endian byte-to-word packer: the first byte lands in word[7:0].
// 'full' is high in the cycle the last byte of a word is being accepted.
module imem_word_pack
    import imem_loader_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic                        byte_valid,
    input  logic [7:0]                  byte_in,
    output logic [8*BYTES_PER_WORD-1:0] word,
    output logic                        full
);

    localparam int CNT_W = $clog2(BYTES_PER_WORD);

    logic [CNT_W-1:0] cnt;

    assign full = byte_valid && (cnt == CNT_W'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            word <= '0;
        end else if (clear) begin
            cnt  <= '0;
            word <= '0;
        end else if (byte_valid) begin
            // Shift right so that after four bytes the first one sits at the bottom.
            word <= {byte_in, word[8*BYTES_PER_WORD-1:8]};
            cnt  <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed byte image into instruction memory, one word per WRITE.
// IMEM_LOADER_CHECKSUM_EN enables the trailing XOR checksum byte (CHECK state).
//
// state  | meaning
// IDLE   | waiting for start; err holds its last value
// LEN_LO | accept low byte of word count N
// LEN_HI | accept high byte of N, decide zero / too long / data
// DATA   | accept payload bytes into the packer
// WRITE  | one-cycle memory write of the packed word
// CHECK  | accept trailing checksum byte (checksum build only)
// FINISH | one-cycle done pulse
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic             WE,
    output logic [31:0]      A,
    output logic [WIDTH-1:0] WD,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int LEN_W = 8 * LEN_BYTES;
    localparam logic [LEN_W:0] DEPTH_W = (LEN_W + 1)'(DEPTH);

    state_t state, state_next;

    logic [LEN_W-1:0]              len;
    logic [LEN_W-1:0]              word_cnt;
    logic [LEN_W-1:0]              word_cnt_inc;
    logic [LEN_W-1:0]              len_hdr;
    logic                          len_big;
    logic                          pack_clear;
    logic                          pack_valid;
    logic                          pack_full;
    logic [8*BYTES_PER_WORD-1:0]   pack_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]                    csum;
`endif

    assign len_hdr      = {rx_data, len[7:0]};
    assign len_big      = {1'b0, len_hdr} > DEPTH_W;
    assign word_cnt_inc = word_cnt + 1'b1;
    assign pack_clear   = (state == IDLE) && start;
    assign pack_valid   = (state == DATA) && rx_valid;

    imem_word_pack u_pack (
        .clk        (clk),
        .rst        (rst),
        .clear      (pack_clear),
        .byte_valid (pack_valid),
        .byte_in    (rx_data),
        .word       (pack_word),
        .full       (pack_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        rx_ready   = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = LEN_LO;
            end
            LEN_LO: begin
                rx_ready = 1'b1;
                if (rx_valid) state_next = LEN_HI;
            end
            LEN_HI: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    if (len_hdr == '0) state_next = FINISH;
                    else if (len_big)  state_next = IDLE;
                    else               state_next = DATA;
                end
            end
            DATA: begin
                rx_ready = 1'b1;
                if (pack_full) state_next = WRITE;
            end
            WRITE: begin
                if (word_cnt_inc < len) state_next = DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
                else                    state_next = CHECK;
`else
                else                    state_next = FINISH;
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHECK: begin
                rx_ready = 1'b1;
                if (rx_valid) state_next = (rx_data == csum) ? FINISH : IDLE;
            end
`endif
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len      <= '0;
            word_cnt <= '0;
            err      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        err      <= 1'b0;
                        word_cnt <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum     <= '0;
`endif
                    end
                end
                LEN_LO: if (rx_valid) len[7:0] <= rx_data;
                LEN_HI: begin
                    if (rx_valid) begin
                        len[LEN_W-1:8] <= rx_data;
                        if (len_big) err <= 1'b1;
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                DATA:  if (rx_valid) csum <= csum ^ rx_data;
                CHECK: if (rx_valid && (rx_data != csum)) err <= 1'b1;
`endif
                WRITE: word_cnt <= word_cnt_inc;
                default: ;
            endcase
        end
    end

    // Address and data are forced to zero outside WRITE so reset and idle look identical.
    assign WE   = (state == WRITE);
    assign A    = WE ? {{(30 - LEN_W){1'b0}}, word_cnt, 2'b00} : 32'd0;
    assign WD   = WE ? WIDTH'(pack_word) : '0;
    assign busy = (state != IDLE);
    assign done = (state == FINISH);

endmodule
